// File: rtl/reaction_timer_core.sv
// Reaction-timer control core: random wait after start, GO LED, millisecond
// BCD count until react, and active-low segment patterns for the scan driver.
module reaction_timer_core #(
  parameter int unsigned MIN_WAIT_MS = 1000,
  parameter int unsigned RAND_BITS   = 11
) (
  input  logic            clk_in,
  input  logic            rst,
  input  logic            start_btn,
  input  logic            react_btn,
  output logic [3:0][6:0] ssd_out,
  output logic            led_go,
  output logic            led_err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_GO    = 3'd2,
    S_DONE  = 3'd3,
    S_EARLY = 3'd4
  } state_t;

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_R     = 7'b0101111;

  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  logic [1:0]  start_sync_q, react_sync_q;
  logic        start_prev_q, react_prev_q;
  logic        start_p_q, react_p_q;
  logic [15:0] lfsr_q;
  state_t      state_q, state_d;
  logic [12:0] wait_q, wait_d;
  logic [15:0] bcd_q, bcd_d;
  logic [12:0] wait_load_s;

  // Synchronizers, registered edge detect, and the free-running LFSR
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      start_sync_q <= 2'b00;
      react_sync_q <= 2'b00;
      start_prev_q <= 1'b0;
      react_prev_q <= 1'b0;
      start_p_q    <= 1'b0;
      react_p_q    <= 1'b0;
      lfsr_q       <= 16'hACE1;
    end else begin
      start_sync_q <= {start_sync_q[0], start_btn};
      react_sync_q <= {react_sync_q[0], react_btn};
      start_prev_q <= start_sync_q[1];
      react_prev_q <= react_sync_q[1];
      start_p_q    <= start_sync_q[1] & ~start_prev_q;
      react_p_q    <= react_sync_q[1] & ~react_prev_q;
      lfsr_q       <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end
  end

  assign wait_load_s = 13'(MIN_WAIT_MS) + 13'(lfsr_q[RAND_BITS-1:0]);

  // FSM, wait counter and BCD counter registers
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      wait_q  <= 13'd0;
      bcd_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      bcd_q   <= bcd_d;
    end
  end

  // Next-state logic; react beats timer expiry in WAIT
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    bcd_d   = bcd_q;
    case (state_q)
      S_IDLE, S_DONE, S_EARLY: begin
        if (start_p_q) begin
          state_d = S_WAIT;
          wait_d  = wait_load_s;
          bcd_d   = 16'h0000;
        end
      end
      S_WAIT: begin
        if (react_p_q) begin
          state_d = S_EARLY;
        end else if (wait_q == 13'd0) begin
          state_d = S_GO;
        end else begin
          wait_d = wait_q - 13'd1;
        end
      end
      S_GO: begin
        if (react_p_q || (bcd_q == 16'h9999)) begin
          state_d = S_DONE;
        end else begin
          bcd_d = bcd_inc(bcd_q);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Display patterns decoded from the state and BCD registers
  always_comb begin
    ssd_out = {4{SEG_BLANK}};
    case (state_q)
      S_IDLE:  ssd_out = {4{SEG_DASH}};
      S_WAIT:  ssd_out = {4{SEG_BLANK}};
      S_GO, S_DONE: begin
        for (int i = 0; i < 4; i++) begin
          ssd_out[i] = seg_digit(bcd_q[i*4 +: 4]);
        end
      end
      S_EARLY: ssd_out = {SEG_BLANK, SEG_E, SEG_R, SEG_R};
      default: ssd_out = {4{SEG_BLANK}};
    endcase
  end

  assign led_go  = (state_q == S_GO);
  assign led_err = (state_q == S_EARLY);

endmodule

// File: tb/tb_reaction_timer_core.sv
// Scoreboard bench for reaction_timer_core: expected display/LED mode changes
// are queued with their cycle number and checked by an independent monitor.
module tb_reaction_timer_core;

  localparam int MIN_WAIT = 1000;
  localparam int RBITS    = 11;

  localparam int C_IDLE  = 0;
  localparam int C_WAIT  = 1;
  localparam int C_GO    = 2;
  localparam int C_DONE  = 3;
  localparam int C_EARLY = 4;

  localparam logic [27:0] ALL_DASH  = {4{7'b0111111}};
  localparam logic [27:0] ALL_BLANK = {4{7'b1111111}};
  localparam logic [27:0] EARLY_PAT = {7'b1111111, 7'b0000110, 7'b0101111, 7'b0101111};

  logic            clk_in = 1'b0;
  logic            rst = 1'b0;
  logic            start_btn = 1'b0;
  logic            react_btn = 1'b0;
  logic [3:0][6:0] ssd_out;
  logic            led_go;
  logic            led_err;

  reaction_timer_core #(.MIN_WAIT_MS(MIN_WAIT), .RAND_BITS(RBITS)) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .start_btn (start_btn),
    .react_btn (react_btn),
    .ssd_out   (ssd_out),
    .led_go    (led_go),
    .led_err   (led_err)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int          cyc;
    int          cls;
    logic [27:0] ssd;
  } ev_t;

  ev_t         exp_q[$];
  int          n_pass = 0;
  int          n_total = 0;
  int          cyc;
  logic [15:0] lfsr_m;
  logic [6:0]  seg_tab [0:9];

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    logic [15:0] b;
    b = (v ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 16'd1;
    return (v >> 1) | (b << 15);
  endfunction

  function automatic logic [15:0] lfsr_adv(input logic [15:0] v, input int n);
    logic [15:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = lfsr_next(r);
    return r;
  endfunction

  function automatic logic [27:0] exp_digits(input int n);
    return {seg_tab[(n / 1000) % 10], seg_tab[(n / 100) % 10],
            seg_tab[(n / 10) % 10], seg_tab[n % 10]};
  endfunction

  function automatic int classify(input logic go, input logic err, input logic [27:0] s);
    if (err) return C_EARLY;
    if (go) return C_GO;
    if (s == ALL_DASH) return C_IDLE;
    if (s == ALL_BLANK) return C_WAIT;
    return C_DONE;
  endfunction

  // Reference cycle count and LFSR, both restarted by reset
  always @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cyc    <= 0;
      lfsr_m <= 16'hACE1;
    end else begin
      cyc    <= cyc + 1;
      lfsr_m <= lfsr_next(lfsr_m);
    end
  end

  task automatic push_ev(input int c, input int cls, input logic [27:0] s);
    ev_t e;
    e.cyc = c;
    e.cls = cls;
    e.ssd = s;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) @(negedge clk_in);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      @(negedge clk_in);
      n++;
    end
    if (exp_q.size() > 0) begin
      n_total++;
      $display("FAIL drain_timeout: %0d expected events still pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Press start (optionally react too) now; returns the cycle GO would begin
  task automatic start_press(input bit also_react, input int hold, output int g);
    int          c;
    logic [15:0] l;
    c = cyc;
    start_btn = 1'b1;
    if (also_react) react_btn = 1'b1;
    l = lfsr_adv(lfsr_m, 3);
    g = c + 5 + MIN_WAIT + (int'(l) & ((1 << RBITS) - 1));
    push_ev(c + 4, C_WAIT, ALL_BLANK);
    if (hold > 0) begin
      step(hold);
      start_btn = 1'b0;
      react_btn = 1'b0;
    end
  endtask

  task automatic react_at(input int g, input int d);
    wait_to(g + d - 3);
    react_btn = 1'b1;
    push_ev(g + d + 1, C_DONE, exp_digits(d));
    step(2);
    react_btn = 1'b0;
  endtask

  task automatic run_game(input int d, input int hold);
    int g;
    start_press(1'b0, hold, g);
    push_ev(g, C_GO, exp_digits(0));
    react_at(g, d);
    drain(6000);
    step(5);
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1;
    check("async_reset_ssd", 32'(ssd_out), 32'(ALL_DASH));
    check("async_reset_led_go", 32'(led_go), 32'd0);
    check("async_reset_led_err", 32'(led_err), 32'd0);
    exp_q.delete();
    @(negedge clk_in);
    #2 rst = 1'b0;
    @(negedge clk_in);
  endtask

  // Monitor: every change of display/LED mode must match the next expectation
  initial begin
    int  prev_cls;
    int  cur;
    ev_t e;
    prev_cls = C_IDLE;
    forever begin
      @(negedge clk_in);
      if (rst) begin
        prev_cls = C_IDLE;
      end else begin
        cur = classify(led_go, led_err, ssd_out);
        if (cur != prev_cls) begin
          n_total++;
          if (exp_q.size() == 0) begin
            $display("FAIL unexpected_event: cycle %0d class %0d ssd %h, none expected",
                     cyc, cur, ssd_out);
          end else begin
            e = exp_q.pop_front();
            if (e.cyc == cyc && e.cls == cur && e.ssd == ssd_out) n_pass++;
            else $display("FAIL event: got cycle %0d class %0d ssd %h, expected cycle %0d class %0d ssd %h",
                          cyc, cur, ssd_out, e.cyc, e.cls, e.ssd);
          end
          prev_cls = cur;
        end
      end
    end
  end

  initial begin
    int g;
    int c;
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    #1 rst = 1'b1;
    #1;
    check("reset_ssd", 32'(ssd_out), 32'(ALL_DASH));
    check("reset_led_go", 32'(led_go), 32'd0);
    check("reset_led_err", 32'(led_err), 32'd0);
    repeat (2) @(negedge clk_in);
    #2 rst = 1'b0;
    @(negedge clk_in);

    // React presses in IDLE are ignored
    for (int i = 0; i < 3; i++) begin
      react_btn = 1'b1;
      step(3);
      react_btn = 1'b0;
      step(3);
    end
    step(10);
    check("idle_react_ssd", 32'(ssd_out), 32'(ALL_DASH));
    check("idle_react_led_go", 32'(led_go), 32'd0);

    // Simultaneous press from IDLE enters WAIT; again in WAIT gives EARLY
    start_press(1'b1, 3, g);
    step(15);
    c = cyc;
    start_btn = 1'b1;
    react_btn = 1'b1;
    push_ev(c + 4, C_EARLY, EARLY_PAT);
    step(3);
    start_btn = 1'b0;
    react_btn = 1'b0;
    drain(100);
    check("early_led_err", 32'(led_err), 32'd1);
    check("early_ssd", 32'(ssd_out), 32'(EARLY_PAT));

    // Normal runs, including zero count and the 0999/1000 carry boundary
    run_game(0, 2);
    run_game(250, 1);
    run_game(999, 4);
    run_game(1000, 3);
    for (int i = 0; i < 3; i++) run_game(int'($urandom_range(1, 1500)), int'($urandom_range(1, 5)));

    // Early press from DONE, then a fresh run from EARLY
    start_press(1'b0, 2, g);
    c = cyc + int'($urandom_range(10, 900));
    wait_to(c);
    react_btn = 1'b1;
    push_ev(c + 4, C_EARLY, EARLY_PAT);
    step(2);
    react_btn = 1'b0;
    drain(2000);
    run_game(int'($urandom_range(1, 1500)), 2);

    // Holding start through WAIT, GO and DONE causes no restart
    start_press(1'b0, 0, g);
    push_ev(g, C_GO, exp_digits(0));
    react_at(g, 321);
    drain(6000);
    step(20);
    start_btn = 1'b0;
    step(20);

    // Asynchronous reset mid-WAIT and mid-GO
    start_press(1'b0, 2, g);
    step(100);
    pulse_reset();
    start_press(1'b0, 2, g);
    push_ev(g, C_GO, exp_digits(0));
    wait_to(g + 300);
    pulse_reset();
    step(10);
    run_game(int'($urandom_range(1, 1500)), 3);

    // Timeout: DONE after 9999 with no wrap
    start_press(1'b0, 2, g);
    push_ev(g, C_GO, exp_digits(0));
    push_ev(g + 10000, C_DONE, exp_digits(9999));
    drain(15000);
    step(50);
    check("timeout_hold_ssd", 32'(ssd_out), 32'(exp_digits(9999)));
    check("timeout_led_go", 32'(led_go), 32'd0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
